// File: rtl/mul_seq_32b.sv
// Iterative 32x32 shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU using an external adder.
// Optional feature macro: MUL_SIGNED_EN enables sign-magnitude handling for MULH/MULHSU.
module mul_seq_32b (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [1:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        kill_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] result_o,
   output logic [31:0] adder_a_o,
   output logic [31:0] adder_b_o,
   input  logic [31:0] adder_sum_i,
   input  logic        adder_carry_i
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state, state_nxt;
   logic [1:0]  op;
   logic [31:0] hi, lo, mcand;
   logic [4:0]  cnt;
   logic        accept;
   logic [31:0] mag_a, mag_b;

   assign accept = (state == IDLE) && valid_i && !kill_i;

`ifdef MUL_SIGNED_EN
   logic        signed_a, signed_b, neg_in, neg;
   logic [63:0] prod_neg;

   assign signed_a = (op_i == 2'b01) || (op_i == 2'b10);
   assign signed_b = (op_i == 2'b01);
   assign mag_a    = (signed_a && a_i[31]) ? (~a_i + 32'd1) : a_i;
   assign mag_b    = (signed_b && b_i[31]) ? (~b_i + 32'd1) : b_i;
   assign neg_in   = (signed_a && a_i[31]) ^ (signed_b && b_i[31]);
   assign prod_neg = ~{hi, lo} + 64'd1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     neg <= 1'b0;
      else if (accept) neg <= neg_in;
   end
`else
   assign mag_a = a_i;
   assign mag_b = b_i;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_o   = 1'b0;
      valid_o   = 1'b0;
      result_o  = '0;
      adder_a_o = '0;
      adder_b_o = '0;
      case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i && !kill_i) state_nxt = CALC;
         end
         CALC: begin
            adder_a_o = hi;
            adder_b_o = lo[0] ? mcand : '0;
            if (kill_i)              state_nxt = IDLE;
            else if (cnt == 5'd31)   state_nxt = FIX;
         end
         FIX: begin
            state_nxt = kill_i ? IDLE : DONE;
         end
         DONE: begin
            valid_o  = 1'b1;
            result_o = (op == 2'b00) ? lo : hi;
            if (kill_i || ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // {hi,lo} shifts right as one 65-bit value: the carry enters hi[31], the
   // adder's LSB drops into lo[31], and the consumed multiplier bit falls off.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op    <= '0;
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
         cnt   <= '0;
      end else if (accept) begin
         op    <= op_i;
         mcand <= mag_a;
         lo    <= mag_b;
         hi    <= '0;
         cnt   <= '0;
      end else if (state == CALC && !kill_i) begin
         hi  <= {adder_carry_i, adder_sum_i[31:1]};
         lo  <= {adder_sum_i[0], lo[31:1]};
         cnt <= cnt + 5'd1;
      end
`ifdef MUL_SIGNED_EN
      else if (state == FIX && !kill_i && neg) begin
         {hi, lo} <= prod_neg;
      end
`endif
   end

endmodule

// File: tb/tb_mul_seq_32b.sv
// Directed self-checking bench for mul_seq_32b; models the external adder combinationally.
// Expected values for MULH/MULHSU follow MUL_SIGNED_EN when it is defined.
module tb_mul_seq_32b;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   logic        ready_o;
   logic [1:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        kill_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic [31:0] adder_a_o;
   logic [31:0] adder_b_o;
   logic [31:0] adder_sum_i;
   logic        adder_carry_i;

   int n_checks = 0;
   int n_fail   = 0;

   mul_seq_32b dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .op_i          (op_i),
      .a_i           (a_i),
      .b_i           (b_i),
      .kill_i        (kill_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .result_o      (result_o),
      .adder_a_o     (adder_a_o),
      .adder_b_o     (adder_b_o),
      .adder_sum_i   (adder_sum_i),
      .adder_carry_i (adder_carry_i)
   );

   assign {adder_carry_i, adder_sum_i} = {1'b0, adder_a_o} + {1'b0, adder_b_o};

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      check({tag, " ready before"}, ready_o, 1'b1);
      valid_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      tick();
      valid_i = 1'b0;
      check({tag, " ready busy"}, ready_o, 1'b0);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (valid_o !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({tag, " latency"}, n, 33);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      start_op(tag, op, a, b);
      wait_done(tag);
      check({tag, " result"}, result_o, exp);
      tick();
      check({tag, " valid drop"}, valid_o, 1'b0);
      check({tag, " ready back"}, ready_o, 1'b1);
   endtask

   logic [31:0] held;
   logic        saw_valid;

   initial begin
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      op_i    = 2'b00;
      a_i     = '0;
      b_i     = '0;
      kill_i  = 1'b0;
      ready_i = 1'b1;
      #1;
      check("rst ready", ready_o, 1'b1);
      check("rst valid", valid_o, 1'b0);
      check("rst result", result_o, 32'h0);
      check("rst adder_a", adder_a_o, 32'h0);
      check("rst adder_b", adder_b_o, 32'h0);
      tick();
      rst_ni = 1'b1;
      tick();

      // first CALC cycle: hi=0, multiplier LSB set -> B addend is mcand
      start_op("adder", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("adder_a calc0", adder_a_o, 32'h0);
      check("adder_b calc0", adder_b_o, 32'hFFFF_FFFF);
      wait_done("adder");
      check("adder result", result_o, 32'hFFFF_FFFE);
      check("adder_a done", adder_a_o, 32'h0);
      tick();

      run_op("mulhu ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("mul ff",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
`ifdef MUL_SIGNED_EN
      run_op("mulh m1x1", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
      run_op("mulhsu",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
`else
      run_op("mulh m1x1", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      run_op("mulhsu",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
`endif
      run_op("mulh min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_op("mul hsu",   2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op("mul 1234",  2'b00, 32'h0001_2345, 32'h0000_1000, 32'h1234_5000);
      run_op("mulhu mix", 2'b11, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234);

      // back-pressure in DONE
      ready_i = 1'b0;
      start_op("bp", 2'b00, 32'h0000_0007, 32'h0000_0009);
      wait_done("bp");
      held = result_o;
      check("bp result", held, 32'h0000_003F);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            valid_i = 1'b1;
            op_i    = 2'b11;
            a_i     = 32'hDEAD_BEEF;
            b_i     = 32'h1234_5678;
         end
         tick();
         valid_i = 1'b0;
         check("bp valid", valid_o, 1'b1);
         check("bp stable", result_o, held);
         check("bp ready", ready_o, 1'b0);
      end
      ready_i = 1'b1;
      tick();
      check("bp release ready", ready_o, 1'b1);
      check("bp release valid", valid_o, 1'b0);

      // flush at cnt=10
      start_op("kill", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (10) tick();
      kill_i = 1'b1;
      tick();
      kill_i = 1'b0;
      check("kill ready", ready_o, 1'b1);
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (valid_o) saw_valid = 1'b1;
         tick();
      end
      check("kill no valid", saw_valid, 1'b0);
      run_op("after kill", 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);

      // kill in IDLE beats valid_i
      kill_i  = 1'b1;
      valid_i = 1'b1;
      tick();
      kill_i  = 1'b0;
      valid_i = 1'b0;
      check("idle kill ready", ready_o, 1'b1);

      // asynchronous reset during CALC
      start_op("arst", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (5) tick();
      rst_ni = 1'b0;
      #1;
      check("arst ready", ready_o, 1'b1);
      check("arst valid", valid_o, 1'b0);
      check("arst result", result_o, 32'h0);
      check("arst adder_a", adder_a_o, 32'h0);
      check("arst adder_b", adder_b_o, 32'h0);
      #3;
      rst_ni = 1'b1;
      tick();
      check("arst post ready", ready_o, 1'b1);
      check("arst post valid", valid_o, 1'b0);
      run_op("after arst", 2'b11, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
